id_exe_reg: RTL and testbench

ID_EXE_REG -- requirements
Module: id_exe_reg

---
 rtl/id_exe_reg.sv | 114 +++++++++++
 tb/tb_id_exe_reg.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures decoded instruction fields, gates control
// bits by the condition check, and inserts counted bubbles on (deferred) flush.
module id_exe_reg #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              cond_ok,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       val_rn_in,
  input  logic [31:0]       val_rm_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [3:0]        status_in,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic [3:0]        exe_cmd_out,
  output logic [31:0]       pc_out,
  output logic [31:0]       val_rn_out,
  output logic [31:0]       val_rm_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [3:0]        status_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic pending_flush;
  logic bubble_c;
  logic cnt_sat_c;

  // A flush seen while frozen is remembered and merged with any live flush.
  assign bubble_c  = flush | pending_flush;
  assign cnt_sat_c = &bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_out         <= 1'b0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      exe_cmd_out       <= 4'd0;
      pc_out            <= 32'd0;
      val_rn_out        <= 32'd0;
      val_rm_out        <= 32'd0;
      dest_out          <= 4'd0;
      src1_out          <= 4'd0;
      src2_out          <= 4'd0;
      imm_out           <= 1'b0;
      shift_operand_out <= 12'd0;
      signed_imm_24_out <= 24'd0;
      status_out        <= 4'd0;
      valid_out         <= 1'b0;
      bubble_cnt        <= '0;
      pending_flush     <= 1'b0;
    end else if (freeze) begin
      if (flush) begin
        pending_flush <= 1'b1;
      end
    end else if (bubble_c) begin
      // Bubble: kill control and ALU command, leave operands as they were.
      wb_en_out     <= 1'b0;
      mem_r_en_out  <= 1'b0;
      mem_w_en_out  <= 1'b0;
      b_out         <= 1'b0;
      s_out         <= 1'b0;
      exe_cmd_out   <= 4'd0;
      valid_out     <= 1'b0;
      pending_flush <= 1'b0;
      if (!cnt_sat_c) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else begin
      wb_en_out         <= wb_en_in & cond_ok;
      mem_r_en_out      <= mem_r_en_in & cond_ok;
      mem_w_en_out      <= mem_w_en_in & cond_ok;
      b_out             <= b_in & cond_ok;
      s_out             <= s_in & cond_ok;
      exe_cmd_out       <= exe_cmd_in;
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      dest_out          <= dest_in;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      imm_out           <= imm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm_24_out <= signed_imm_24_in;
      status_out        <= status_in;
      valid_out         <= cond_ok;
    end
  end

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg against a field-level reference model.
module tb_id_exe_reg;

  localparam int unsigned CW    = 2;
  localparam int unsigned FW    = 158;
  localparam int unsigned OW    = FW + 1 + CW;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic freeze = 1'b0, flush = 1'b0, cond_ok = 1'b0;
  logic wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, b_in = 1'b0, s_in = 1'b0;
  logic [3:0]  exe_cmd_in = '0, dest_in = '0, src1_in = '0, src2_in = '0, status_in = '0;
  logic [31:0] pc_in = '0, val_rn_in = '0, val_rm_in = '0;
  logic        imm_in = 1'b0;
  logic [11:0] shift_operand_in = '0;
  logic [23:0] signed_imm_24_in = '0;

  logic wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, valid_out;
  logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, status_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic [CW-1:0] bubble_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: last stage contents, validity, pending flag, bubble count.
  logic [FW-1:0] m_out;
  logic          m_valid;
  logic          m_pend;
  int            m_cnt;

  id_exe_reg #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .cond_ok(cond_ok),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .src1_in(src1_in), .src2_in(src2_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .status_in(status_in),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out), .pc_out(pc_out),
    .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .dest_out(dest_out),
    .src1_out(src1_out), .src2_out(src2_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .status_out(status_out), .valid_out(valid_out), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] in_fields();
    return {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in, pc_in,
            val_rn_in, val_rm_in, dest_in, src1_in, src2_in, imm_in,
            shift_operand_in, signed_imm_24_in, status_in};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out, pc_out,
            val_rn_out, val_rm_out, dest_out, src1_out, src2_out, imm_out,
            shift_operand_out, signed_imm_24_out, status_out, valid_out, bubble_cnt};
  endfunction

  function automatic logic [OW-1:0] expv();
    return {m_out, m_valid, CW'(m_cnt)};
  endfunction

  task automatic model_reset();
    m_out = '0; m_valid = 1'b0; m_pend = 1'b0; m_cnt = 0;
  endtask

  // One clock edge of the stage, from the behavioural rules.
  task automatic model_edge();
    logic [FW-1:0] f;
    if (freeze) begin
      if (flush) m_pend = 1'b1;
    end else if (flush || m_pend) begin
      m_out[FW-1 -: 9] = '0;
      m_valid = 1'b0;
      m_pend  = 1'b0;
      m_cnt   = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else begin
      f = in_fields();
      if (!cond_ok) f[FW-1 -: 5] = '0;
      m_out   = f;
      m_valid = cond_ok;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic drive_random();
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in} = 5'($urandom);
    exe_cmd_in = 4'($urandom); dest_in = 4'($urandom);
    src1_in = 4'($urandom); src2_in = 4'($urandom); status_in = 4'($urandom);
    pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
    imm_in = 1'($urandom); shift_operand_in = 12'($urandom);
    signed_imm_24_in = 24'($urandom); cond_ok = 1'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
    freeze = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    drive_random(); cond_ok = 1'b1; flush = 1'b1;
    step(); freeze = 1'b1; step();
    checks++;
    if (obs() !== '0) begin
      failures++; $display("FAIL reset_hold got=%h want=0", obs());
    end
    rst_n = 1'b1; freeze = 1'b0; flush = 1'b0;
    drive_random(); cond_ok = 1'b1;
    step();
    checks++;
    if (obs() !== expv() || valid_out !== 1'b1 || bubble_cnt !== '0) begin
      failures++; $display("FAIL first_load got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_load();
    do_reset();
    drive_random();
    pc_in = 32'h10; val_rn_in = 32'd5; wb_en_in = 1'b1; cond_ok = 1'b1;
    step();
    checks++;
    if (pc_out !== 32'h10 || val_rn_out !== 32'd5 || wb_en_out !== 1'b1 ||
        valid_out !== 1'b1 || obs() !== expv()) begin
      failures++; $display("FAIL load got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_cond_squash();
    do_reset();
    drive_random();
    cond_ok = 1'b0; mem_w_en_in = 1'b1; val_rm_in = 32'hAA;
    step();
    checks++;
    if (mem_w_en_out !== 1'b0 || val_rm_out !== 32'hAA || valid_out !== 1'b0 ||
        bubble_cnt !== '0 || obs() !== expv()) begin
      failures++; $display("FAIL cond_squash got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_flush_freeze();
    do_reset();
    drive_random(); pc_in = 32'h10; wb_en_in = 1'b1; cond_ok = 1'b1;
    step();
    freeze = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      drive_random();
      flush = (c == 2);
      step();
      checks++;
      if (pc_out !== 32'h10 || wb_en_out !== 1'b1 || valid_out !== 1'b1 ||
          bubble_cnt !== '0 || obs() !== expv()) begin
        failures++; $display("FAIL freeze_hold_c%0d got=%h want=%h", c, obs(), expv());
      end
    end
    freeze = 1'b0; flush = 1'b0; drive_random();
    step();
    checks++;
    if (valid_out !== 1'b0 || bubble_cnt !== CW'(1) || wb_en_out !== 1'b0 ||
        exe_cmd_out !== 4'd0 || pc_out !== 32'h10 || obs() !== expv()) begin
      failures++; $display("FAIL deferred_bubble got=%h want=%h", obs(), expv());
    end
    drive_random(); cond_ok = 1'b1;
    step();
    checks++;
    if (valid_out !== 1'b1 || bubble_cnt !== CW'(1) || obs() !== expv()) begin
      failures++; $display("FAIL after_bubble got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive_random(); step();
    freeze = 1'b1; flush = 1'b1; step();
    freeze = 1'b0; flush = 1'b1; drive_random(); step();
    checks++;
    if (valid_out !== 1'b0 || bubble_cnt !== CW'(1) || obs() !== expv()) begin
      failures++; $display("FAIL merged_bubble got=%h want=%h", obs(), expv());
    end
    flush = 1'b0; drive_random(); cond_ok = 1'b1; step();
    checks++;
    if (valid_out !== 1'b1 || bubble_cnt !== CW'(1) || obs() !== expv()) begin
      failures++; $display("FAIL merged_single got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    flush = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive_random(); step();
      checks++;
      if (bubble_cnt !== CW'((i < 3) ? i : 3) || obs() !== expv()) begin
        failures++; $display("FAIL saturate_%0d got=%h want=%h", i, obs(), expv());
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_random(); cond_ok = 1'b1; step();
    flush = 1'b1; step();
    flush = 1'b0; drive_random(); cond_ok = 1'b1; step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== '0) begin
      failures++; $display("FAIL async_reset got=%h want=0", obs());
    end
    model_reset(); rst_n = 1'b1;
    // A flush remembered during freeze must not survive reset.
    freeze = 1'b1; flush = 1'b1; step();
    freeze = 1'b0; flush = 1'b0;
    #2; rst_n = 1'b0; #2; model_reset(); rst_n = 1'b1;
    drive_random(); cond_ok = 1'b1; step();
    checks++;
    if (valid_out !== 1'b1 || bubble_cnt !== '0 || obs() !== expv()) begin
      failures++; $display("FAIL reset_drops_pending got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive_random();
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 4) == 0);
      step();
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL random_%0d got=%h want=%h", i, obs(), expv());
      end
    end
    freeze = 1'b0; flush = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    test_reset();
    test_load();
    test_cond_squash();
    test_flush_freeze();
    test_simultaneous();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
